// File: rtl/irq_controller.sv
// irq_controller: collects four peripheral interrupt lines (timer, mouse, IR,
// spare), arbitrates them onto one processor interrupt and routes the
// processor acknowledge back to the granted source only. The ISR sees a
// 4-byte register window at BaseAddr: Pending (W1C), Mask, Vector, Mode.
// Optional build macro: IRQ_ROUND_ROBIN_EN adds a Mode register (+3, bit0)
// that selects round-robin arbitration. Without it, arbitration is fixed
// priority (source 0 highest) and +3 reads 8'h00.
//
// state   | meaning
// IDLE    | no grant outstanding, arbitrating enabled pending sources
// RAISE   | CPU_IRQ asserted for ActiveId, waiting for CPU_ACK or withdrawal
// HOLDOFF | one-cycle gap after an ack before the next arbitration
module irq_controller #(
  parameter logic [7:0] BaseAddr    = 8'hE0,
  parameter logic [3:0] InitialMask = 4'hF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  inout  wire  [7:0] io_bus_data,
  input  logic [7:0] i_bus_addr,
  input  logic       i_bus_we,
  input  logic [3:0] i_src_irq,
  output logic [3:0] o_src_ack,
  output logic       o_cpu_irq,
  input  logic       i_cpu_ack
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAISE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [3:0] r_src_irq_q;
  logic [3:0] r_pending;
  logic [3:0] r_mask;
  logic [3:0] r_src_ack;
  logic [1:0] r_active_id;
  logic       r_active_valid;
  logic       r_rd_en;
  logic [1:0] r_rd_sel;

  logic [7:0] w_offset;
  logic       w_in_win;
  logic       w_wr;
  logic       w_wr_pend;
  logic       w_wr_mask;
  logic [3:0] w_wdata;
  logic [3:0] w_rise;
  logic [3:0] w_req;
  logic       w_ack;
  logic       w_withdraw;
  logic [1:0] w_start;
  logic [1:0] w_grant_id;
  logic       w_found;
  logic [3:0] w_pending_nxt;
  logic [7:0] w_rdata;

`ifdef IRQ_ROUND_ROBIN_EN
  logic       r_mode;
  logic [1:0] r_last_grant;
`endif

  // Window decode is a subtraction so any BaseAddr works, aligned or not.
  assign w_offset  = i_bus_addr - BaseAddr;
  assign w_in_win  = (w_offset < 8'd4);
  assign w_wr      = w_in_win & i_bus_we;
  assign w_wr_pend = w_wr & (w_offset[1:0] == 2'd0);
  assign w_wr_mask = w_wr & (w_offset[1:0] == 2'd1);
  assign w_wdata   = io_bus_data[3:0];

  assign w_rise = i_src_irq & ~r_src_irq_q;
  assign w_req  = r_pending & r_mask;
  assign w_ack  = (r_state == ST_RAISE) & i_cpu_ack;
  // A W1C of the active bit pulls the request back, unless a fresh edge on
  // that same source lands in the same cycle (the set wins, so it stays).
  assign w_withdraw = (r_state == ST_RAISE) & ~i_cpu_ack & w_wr_pend &
                      w_wdata[r_active_id] & ~w_rise[r_active_id];

  // Arbitration: scan upward with wrap from a start index
  always_comb begin
`ifdef IRQ_ROUND_ROBIN_EN
    w_start = r_mode ? (r_last_grant + 2'd1) : 2'd0;
`else
    w_start = 2'd0;
`endif
    w_grant_id = 2'd0;
    w_found    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && w_req[w_start + 2'(k)]) begin
        w_grant_id = w_start + 2'(k);
        w_found    = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (|w_req) w_state_nxt = ST_RAISE;
      ST_RAISE: begin
        if (w_ack)           w_state_nxt = ST_HOLDOFF;
        else if (w_withdraw) w_state_nxt = ST_IDLE;
      end
      ST_HOLDOFF: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: the processor line follows RAISE so reset drops it at once
  always_comb begin
    o_cpu_irq = (r_state == ST_RAISE);
    o_src_ack = r_src_ack;
  end

  // Input edge detector and one-cycle acknowledge pulse to the granted source
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_src_irq_q <= 4'd0;
      r_src_ack   <= 4'd0;
    end else begin
      r_src_irq_q <= i_src_irq;
      r_src_ack   <= w_ack ? (4'b0001 << r_active_id) : 4'd0;
    end
  end

  // Pending update: W1C and ack-clear first, then new edges override both
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wr_pend) w_pending_nxt = w_pending_nxt & ~w_wdata;
    if (w_ack)     w_pending_nxt[r_active_id] = 1'b0;
    w_pending_nxt = w_pending_nxt | w_rise;
  end

  // Pending and mask registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= 4'd0;
      r_mask    <= InitialMask;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_wr_mask) r_mask <= w_wdata;
    end
  end

  // Active grant: latched on arbitration, dropped on ack or withdrawal
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active_id    <= 2'd0;
      r_active_valid <= 1'b0;
    end else if (r_state == ST_IDLE && (|w_req)) begin
      r_active_id    <= w_grant_id;
      r_active_valid <= 1'b1;
    end else if (w_ack || w_withdraw) begin
      r_active_id    <= 2'd0;
      r_active_valid <= 1'b0;
    end
  end

`ifdef IRQ_ROUND_ROBIN_EN
  // Mode register and the last granted source for round-robin start point
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode       <= 1'b0;
      r_last_grant <= 2'd3;
    end else begin
      if (w_wr && w_offset[1:0] == 2'd3) r_mode <= w_wdata[0];
      if (w_ack) r_last_grant <= r_active_id;
    end
  end
`endif

  // Registered read select so the bus is driven one cycle after the address
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_en  <= 1'b0;
      r_rd_sel <= 2'd0;
    end else begin
      r_rd_en  <= w_in_win & ~i_bus_we;
      r_rd_sel <= w_offset[1:0];
    end
  end

  // Read data mux
  always_comb begin
    w_rdata = 8'h00;
    case (r_rd_sel)
      2'd0: w_rdata = {4'h0, r_pending};
      2'd1: w_rdata = {4'h0, r_mask};
      2'd2: w_rdata = {r_active_valid, 5'b0, r_active_id};
`ifdef IRQ_ROUND_ROBIN_EN
      2'd3: w_rdata = {7'b0, r_mode};
`else
      2'd3: w_rdata = 8'h00;
`endif
      default: w_rdata = 8'h00;
    endcase
  end

  assign io_bus_data = r_rd_en ? w_rdata : 8'hzz;

endmodule
